// File: rtl/channel_sweep_ctrl.sv
// Display-mode selector and automatic AWGN noise sweep scheduler for the 16-QAM link.
// Steps noise through four levels, waits for Costas lock, dwells, and records lock failures.
module channel_sweep_ctrl #(
  parameter int unsigned NOISE_MAG_WIDTH = 8,
  parameter int unsigned LEVEL0          = 0,
  parameter int unsigned LEVEL1          = 20,
  parameter int unsigned LEVEL2          = 50,
  parameter int unsigned LEVEL3          = 100,
  parameter int unsigned SETTLE_SYMS     = 256,
  parameter int unsigned DWELL_SYMS      = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_mode,
  input  logic                       btn_sweep,
  input  logic                       sym_tick,
  input  logic                       demod_lock,
  output logic [NOISE_MAG_WIDTH-1:0] noise_magnitude,
  output logic [1:0]                 disp_sel,
  output logic [1:0]                 level_idx,
  output logic                       sweep_busy,
  output logic                       level_done,
  output logic                       sweep_done,
  output logic [3:0]                 lock_fail
);

  localparam logic [15:0] SettleTarget = 16'(SETTLE_SYMS);
  localparam logic [15:0] DwellTarget  = 16'(DWELL_SYMS);
  localparam logic [NOISE_MAG_WIDTH-1:0] Level0Mag = NOISE_MAG_WIDTH'(LEVEL0);
  localparam logic [NOISE_MAG_WIDTH-1:0] Level1Mag = NOISE_MAG_WIDTH'(LEVEL1);
  localparam logic [NOISE_MAG_WIDTH-1:0] Level2Mag = NOISE_MAG_WIDTH'(LEVEL2);
  localparam logic [NOISE_MAG_WIDTH-1:0] Level3Mag = NOISE_MAG_WIDTH'(LEVEL3);

  typedef enum logic [2:0] {StIdle, StApply, StSettle, StDwell, StNext} state_e;

  state_e                      state_q, state_d;
  logic [1:0]                  man_sel_q, man_sel_d;
  logic [15:0]                 sym_cnt_q, sym_cnt_d, sym_cnt_inc;
  logic [NOISE_MAG_WIDTH-1:0]  noise_q, noise_d, level_mag;
  logic [1:0]                  level_idx_q, level_idx_d;
  logic [3:0]                  lock_fail_q, lock_fail_d;
  logic [1:0]                  disp_sel_q, disp_sel_d;
  logic                        busy_q, busy_d;
  logic                        level_done_q, level_done_d;
  logic                        sweep_done_q, sweep_done_d;

  always_comb begin
    level_mag = Level0Mag;
    unique case (level_idx_q)
      2'd0: level_mag = Level0Mag;
      2'd1: level_mag = Level1Mag;
      2'd2: level_mag = Level2Mag;
      2'd3: level_mag = Level3Mag;
      default: level_mag = Level0Mag;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    man_sel_d    = man_sel_q;
    sym_cnt_d    = sym_cnt_q;
    sym_cnt_inc  = sym_cnt_q + 16'd1;
    noise_d      = noise_q;
    level_idx_d  = level_idx_q;
    lock_fail_d  = lock_fail_q;
    sweep_done_d = 1'b0;

    if (btn_mode) begin
      man_sel_d = man_sel_q + 2'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (btn_sweep) begin
          state_d     = StApply;
          level_idx_d = 2'd0;
          lock_fail_d = 4'd0;
        end
      end
      StApply: begin
        noise_d   = level_mag;
        sym_cnt_d = 16'd0;
        state_d   = StSettle;
      end
      StSettle: begin
        if (sym_tick) begin
          sym_cnt_d = sym_cnt_inc;
          if (sym_cnt_inc == SettleTarget) begin
            if (demod_lock) begin
              sym_cnt_d = 16'd0;
              state_d   = StDwell;
            end else begin
              lock_fail_d[level_idx_q] = 1'b1;
              state_d                  = StNext;
            end
          end
        end
      end
      StDwell: begin
        if (!demod_lock) begin
          lock_fail_d[level_idx_q] = 1'b1;
        end
        if (sym_tick) begin
          sym_cnt_d = sym_cnt_inc;
          if (sym_cnt_inc == DwellTarget) begin
            state_d = StNext;
          end
        end
      end
      StNext: begin
        if (level_idx_q == 2'd3) begin
          noise_d      = '0;
          sweep_done_d = 1'b1;
          state_d      = StIdle;
        end else begin
          level_idx_d = level_idx_q + 2'd1;
          state_d     = StApply;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over every in-sweep transition; partial results are kept.
    if (state_q != StIdle && btn_sweep) begin
      state_d      = StIdle;
      noise_d      = '0;
      sweep_done_d = 1'b0;
      sym_cnt_d    = sym_cnt_q;
      level_idx_d  = level_idx_q;
      lock_fail_d  = lock_fail_q;
    end

    disp_sel_d   = (state_d == StIdle) ? man_sel_d : 2'd3;
    busy_d       = (state_d != StIdle);
    level_done_d = (state_d == StNext);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      man_sel_q    <= 2'd0;
      sym_cnt_q    <= 16'd0;
      noise_q      <= '0;
      level_idx_q  <= 2'd0;
      lock_fail_q  <= 4'd0;
      disp_sel_q   <= 2'd0;
      busy_q       <= 1'b0;
      level_done_q <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      man_sel_q    <= man_sel_d;
      sym_cnt_q    <= sym_cnt_d;
      noise_q      <= noise_d;
      level_idx_q  <= level_idx_d;
      lock_fail_q  <= lock_fail_d;
      disp_sel_q   <= disp_sel_d;
      busy_q       <= busy_d;
      level_done_q <= level_done_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign noise_magnitude = noise_q;
  assign disp_sel        = disp_sel_q;
  assign level_idx       = level_idx_q;
  assign sweep_busy      = busy_q;
  assign level_done      = level_done_q;
  assign sweep_done      = sweep_done_q;
  assign lock_fail       = lock_fail_q;

endmodule
